// File: rtl/store_aligner.sv
// -----------------------------------------------------------------------------
// store_aligner
//
// Converts one register-width store (SB/SH/SW/SD) into 8-byte-aligned memory
// write beats with lane-shifted data and byte strobes. A store whose bytes
// cross an 8-byte boundary is issued as two sequential beats (low doubleword
// first, then the next doubleword). Each completed store ends with a
// one-cycle done pulse; an illegal store type is dropped with a one-cycle
// err pulse and never reaches memory.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous, active-high reset
//   req_valid  : store request present
//   req_ready  : block can accept a request (high only while idle)
//   req_func3  : store type, 000 SB / 001 SH / 010 SW / 011 SD, 1xx illegal
//   req_addr   : byte address of the store
//   req_data   : right-justified store data (rs2 value)
//   mem_valid  : write beat valid
//   mem_ready  : memory accepts the beat
//   mem_addr   : doubleword-aligned beat address (bits [2:0] always 0)
//   mem_wdata  : lane-shifted write data
//   mem_wstrb  : byte enables, bit i = byte lane i
//   done       : one-cycle pulse, store fully written
//   err        : one-cycle pulse, illegal func3, request dropped
//
// Handshakes (both channels): a transfer happens on a rising edge where
// valid && ready are both high. Once mem_valid is raised it stays high, with
// mem_addr/mem_wdata/mem_wstrb unchanged, until the beat is accepted; it
// never drops without a transfer (only rst abandons a beat). req_ready is a
// pure function of the FSM state and does not depend on req_valid.
//
// The current FSM state is held in the signal `state` (type state_t) so it
// can be observed hierarchically for debug.
// -----------------------------------------------------------------------------
module store_aligner #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wstrb,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t state;
  state_t state_n;

  // ---------------------------------------------------------------------------
  // Request decode (combinational, only meaningful while accepting)
  // ---------------------------------------------------------------------------
  logic [2:0]        req_off;
  logic [3:0]        req_size;
  logic [7:0]        req_mask;
  logic [15:0]       req_strb16;
  logic [63:0]       req_wdata0;
  logic [ADDR_W-1:0] req_base;
  logic              req_split;
  logic              req_illegal;
  logic              accept;

  assign req_off     = req_addr[2:0];
  assign req_size    = 4'd1 << req_func3[1:0];
  assign req_base    = {req_addr[ADDR_W-1:3], 3'b000};
  assign req_illegal = req_func3[2];
  assign accept      = req_valid && req_ready;

  always_comb begin
    req_mask = 8'h00;
    case (req_func3[1:0])
      2'd0:    req_mask = 8'h01;
      2'd1:    req_mask = 8'h03;
      2'd2:    req_mask = 8'h0F;
      default: req_mask = 8'hFF;
    endcase
  end

  // The 16-bit strobe spans both doublewords the store can touch: the low
  // byte enables belong to the first beat, the high byte to the second.
  assign req_strb16 = {8'h00, req_mask} << req_off;
  assign req_wdata0 = req_data << {req_off, 3'b000};

  // off + size never exceeds 15, so a 4-bit sum is enough.
  assign req_split  = ({1'b0, req_off} + req_size) > 4'd8;

  // ---------------------------------------------------------------------------
  // Fields captured at accept time for the second beat
  // ---------------------------------------------------------------------------
  logic [2:0]        off_q;
  logic [63:0]       data_q;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        strb_hi_q;
  logic              split_q;
  logic              latch_en;

  // Second-beat data: the bytes that spilled past lane 7 of the first beat.
  // Only reached when split, so off_q is at least 1 and the shift is < 64.
  logic [6:0]        hi_shift;
  logic [63:0]       beat1_wdata;
  logic [ADDR_W-1:0] beat1_addr;

  assign hi_shift    = 7'd64 - {1'b0, off_q, 3'b000};
  assign beat1_wdata = data_q >> hi_shift;
  // Wraps modulo 2^ADDR_W by plain truncation of the sum.
  assign beat1_addr  = base_q + {{(ADDR_W-4){1'b0}}, 4'd8};

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  logic              mem_valid_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [63:0]       mem_wdata_n;
  logic [7:0]        mem_wstrb_n;
  logic              done_n;
  logic              err_n;

  assign req_ready = (state == IDLE);

  always_comb begin
    state_n     = state;
    mem_valid_n = mem_valid;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_wstrb_n = mem_wstrb;
    done_n      = 1'b0;
    err_n       = 1'b0;
    latch_en    = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (req_illegal) begin
            // Dropped: nothing reaches memory, stay idle.
            err_n = 1'b1;
          end else begin
            latch_en    = 1'b1;
            state_n     = BEAT0;
            mem_valid_n = 1'b1;
            mem_addr_n  = req_base;
            mem_wdata_n = req_wdata0;
            mem_wstrb_n = req_strb16[7:0];
          end
        end
      end

      BEAT0: begin
        if (mem_ready) begin
          if (split_q) begin
            state_n     = BEAT1;
            mem_addr_n  = beat1_addr;
            mem_wdata_n = beat1_wdata;
            mem_wstrb_n = strb_hi_q;
          end else begin
            state_n     = IDLE;
            mem_valid_n = 1'b0;
            mem_addr_n  = '0;
            mem_wdata_n = '0;
            mem_wstrb_n = '0;
            done_n      = 1'b1;
          end
        end
      end

      BEAT1: begin
        if (mem_ready) begin
          state_n     = IDLE;
          mem_valid_n = 1'b0;
          mem_addr_n  = '0;
          mem_wdata_n = '0;
          mem_wstrb_n = '0;
          done_n      = 1'b1;
        end
      end

      default: begin
        state_n     = IDLE;
        mem_valid_n = 1'b0;
        mem_addr_n  = '0;
        mem_wdata_n = '0;
        mem_wstrb_n = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      off_q     <= '0;
      data_q    <= '0;
      base_q    <= '0;
      strb_hi_q <= '0;
      split_q   <= 1'b0;
    end else begin
      state     <= state_n;
      mem_valid <= mem_valid_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_wstrb <= mem_wstrb_n;
      done      <= done_n;
      err       <= err_n;
      if (latch_en) begin
        off_q     <= req_off;
        data_q    <= req_data;
        base_q    <= req_base;
        strb_hi_q <= req_strb16[15:8];
        split_q   <= req_split;
      end
    end
  end

endmodule

// File: tb/tb_store_aligner.sv
// -----------------------------------------------------------------------------
// tb_store_aligner
//
// Directed and randomized stores driven through store_aligner. Expected beats
// come from a byte-level model: each stored byte lands at address addr+i,
// which selects the doubleword (beat) and lane; write data is the store data
// shifted into a 128-bit window spanning both doublewords.
// -----------------------------------------------------------------------------
module tb_store_aligner;

  localparam int ADDR_W = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_func3;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [7:0]        mem_wstrb;
  logic              done;
  logic              err;

  store_aligner #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_func3 (req_func3),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .done      (done),
    .err       (err)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard: one entry per expected beat, {addr, wdata, wstrb}
  // ---------------------------------------------------------------------------
  logic [ADDR_W+64+8-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: enumerate the bytes of the store.
  task automatic model(input logic [2:0] f3, input logic [ADDR_W-1:0] addr,
                       input logic [63:0] data);
    int          size;
    int          off;
    logic [15:0] s16;
    logic [127:0] wide;
    logic [ADDR_W-1:0] base;
    size = 1 << f3[1:0];
    off  = int'(addr[2:0]);
    s16  = '0;
    for (int i = 0; i < size; i++) s16[off + i] = 1'b1;
    wide = {64'h0, data} << (8 * off);
    base = addr & ~ADDR_W'(7);
    exp_q.push_back({base, wide[63:0], s16[7:0]});
    if (s16[15:8] != 8'h00)
      exp_q.push_back({base + ADDR_W'(8), wide[127:64], s16[15:8]});
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one complete store. Called and returns on a falling edge.
  // stall < 0 picks a random stall (0..2) per beat.
  // ---------------------------------------------------------------------------
  task automatic run_store(input logic [2:0] f3, input logic [ADDR_W-1:0] addr,
                           input logic [63:0] data, input int stall);
    logic [ADDR_W+64+8-1:0] e;
    int k;
    exp_q.delete();
    if (!f3[2]) model(f3, addr, data);

    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_func3 = f3;
    req_addr  = addr;
    req_data  = data;
    @(posedge clk);
    @(negedge clk);
    // Scramble request inputs so any failure to latch shows up.
    req_valid = 1'b0;
    req_func3 = 3'($urandom);
    req_addr  = $urandom;
    req_data  = {$urandom, $urandom};

    if (f3[2]) begin
      check("err_pulse", err, 1'b1);
      check("err_no_valid", mem_valid, 1'b0);
      check("err_no_done", done, 1'b0);
      check("err_req_ready", req_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      check("err_one_cycle", err, 1'b0);
      check("err_still_no_valid", mem_valid, 1'b0);
      return;
    end

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      k = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
      for (int s = 0; s <= k; s++) begin
        check("beat_valid", mem_valid, 1'b1);
        check("beat_addr", mem_addr, e[ADDR_W+72-1:72]);
        check("beat_wdata", mem_wdata, e[71:8]);
        check("beat_wstrb", mem_wstrb, e[7:0]);
        check("beat_req_ready", req_ready, 1'b0);
        check("beat_no_done", done, 1'b0);
        check("beat_no_err", err, 1'b0);
        mem_ready = (s == k);
        @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
      end
    end

    check("done_pulse", done, 1'b1);
    check("done_req_ready", req_ready, 1'b1);
    check("done_valid_low", mem_valid, 1'b0);
    check("done_no_err", err, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [ADDR_W+64+8-1:0] e;
    logic [2:0]        f3;
    logic [ADDR_W-1:0] a;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_func3 = '0;
    req_addr  = '0;
    req_data  = '0;
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    check("rst_req_ready", req_ready, 1'b1);
    check("rst_mem_valid", mem_valid, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_mem_wstrb", mem_wstrb, '0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Directed cases
    run_store(3'b000, 32'h0000_1003, 64'hFFFF_FFFF_FFFF_FFAB, 0);  // SB
    run_store(3'b011, 32'h0000_2000, 64'h0123_4567_89AB_CDEF, 0);  // SD aligned
    run_store(3'b010, 32'h0000_3006, 64'h0000_0000_1122_3344, 0);  // SW split
    run_store(3'b001, 32'h0000_4002, 64'h0000_0000_0000_BEEF, 5);  // SH, 5-cycle stall
    run_store(3'b101, 32'h0000_4444, 64'h1234, 0);                 // illegal
    run_store(3'b001, 32'h0000_6007, 64'h0000_0000_0000_A55A, 1);  // SH split
    run_store(3'b011, 32'hFFFF_FFFD, 64'hDEAD_BEEF_CAFE_F00D, 0);  // SD, address wrap

    // Reset while the second beat is pending
    exp_q.delete();
    model(3'b011, 32'h0000_5005, 64'h8877_6655_4433_2211);
    req_valid = 1'b1;
    req_func3 = 3'b011;
    req_addr  = 32'h0000_5005;
    req_data  = 64'h8877_6655_4433_2211;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    e = exp_q.pop_front();
    check("rstmid_b0_addr", mem_addr, e[ADDR_W+72-1:72]);
    check("rstmid_b0_wstrb", mem_wstrb, e[7:0]);
    mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    e = exp_q.pop_front();
    check("rstmid_b1_valid", mem_valid, 1'b1);
    check("rstmid_b1_addr", mem_addr, e[ADDR_W+72-1:72]);
    check("rstmid_b1_wdata", mem_wdata, e[71:8]);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_valid", mem_valid, 1'b0);
    check("rstmid_wstrb", mem_wstrb, 8'h00);
    check("rstmid_addr", mem_addr, '0);
    check("rstmid_req_ready", req_ready, 1'b1);
    check("rstmid_no_done", done, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("rstmid_no_done_late", done, 1'b0);
    check("rstmid_valid_late", mem_valid, 1'b0);

    // Randomized stores
    for (int n = 0; n < 80; n++) begin
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      run_store(f3, a, {$urandom, $urandom}, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/store_aligner.md
# store_aligner

Store-side counterpart of the load sign/zero-extension path: takes a register-width store request (SB/SH/SW/SD), converts it into 8-byte-aligned memory write beats, and produces lane-shifted write data plus byte strobes. Misaligned stores that cross an 8-byte boundary are split into two sequential write beats. The block sits between the MEM stage and the data-memory write port and completes each store with a one-cycle done pulse.

## Interface

- ADDR_W, 32, byte-address width

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  store request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_func3  in  3  store type: 000 SB, 001 SH, 010 SW, 011 SD; 1xx illegal
- req_addr  in  ADDR_W  byte address of the store
- req_data  in  64  store data, right-justified (rs2 value)
- mem_valid  out  1  write beat valid
- mem_ready  in  1  memory accepts the beat
- mem_addr  out  ADDR_W  beat address, bits [2:0] always 0
- mem_wdata  out  64  lane-shifted write data
- mem_wstrb  out  8  byte enables, bit i = byte lane i
- done  out  1  one-cycle pulse: store fully written
- err  out  1  one-cycle pulse: illegal func3, request dropped

## Operation

- States: IDLE, BEAT0, BEAT1.
- Handshake: request accepted on cycle where req_valid && req_ready. Beat transfers on mem_valid && mem_ready.
- On accept, latch: off = req_addr[2:0], size = 1 << func3[1:0] (1/2/4/8 bytes), mask = (1<<size)-1 (8 bits; SD gives 0xFF), data, base = req_addr with [2:0] cleared.
- Illegal func3 (bit 2 set): no beat issued; err pulses the next cycle; state stays IDLE; done not asserted.
- BEAT0: mem_addr = base; mem_wdata = (data << 8*off)[63:0]; mem_wstrb = (mask << off)[7:0].
- Split iff off + size > 8. On BEAT0 handshake: split -> BEAT1, else -> IDLE with done pulse.
- BEAT1: mem_addr = base + 8 (wraps modulo 2^ADDR_W); mem_wdata = data >> 8*(8-off); mem_wstrb = (mask << off)[15:8]. On handshake -> IDLE with done pulse.
- Unused wdata lanes carry the shifted values above (not forced to zero); memory relies on wstrb only.
- mem_addr, mem_wdata, mem_wstrb held stable while mem_valid && !mem_ready.
- Store data is never sign/zero-modified; only bytes selected by size are enabled.

## Timing

- Reset values: req_ready 1, mem_valid 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, done 0, err 0; state IDLE.
- Accept at cycle N -> mem_valid high at N+1 (registered outputs).
- Aligned store, mem_ready tied high: accept N, beat N+1, done N+2; next accept N+2 earliest.
- Split store, mem_ready high: beats N+1, N+2; done N+3.
- done and err are registered, high exactly one cycle, never simultaneously.
- req_ready low from accept through the cycle the done/err pulse is driven; high again in that pulse cycle.
- mem_valid never drops without a handshake; stall of any length is legal.
- rst during BEAT0/BEAT1: abandon the store, return to IDLE with reset values next cycle, no done.

## Test plan

- SB addr 0x1003, data 0xFFFF_FFFF_FFFF_FFAB -> one beat addr 0x1000, wstrb 0x08, wdata[31:24] 0xAB; done one cycle after beat.
- SD addr 0x2000, data 0x0123_4567_89AB_CDEF -> one beat addr 0x2000, wstrb 0xFF, wdata equals data.
- SW addr 0x3006, data 0x1122_3344 -> beat0 addr 0x3000 wstrb 0xC0 wdata[63:48] 0x3344; beat1 addr 0x3008 wstrb 0x03 wdata[15:0] 0x1122; done after beat1.
- SH addr 0x4002 with mem_ready low 5 cycles -> mem_valid/addr/wstrb 0x0C/wdata held constant 5 cycles, req_ready low throughout, single done after handshake.
- func3 3'b101 -> no mem_valid, err pulse one cycle after accept, req_ready high again the same cycle as err.
- SD addr 0x5005, rst asserted during BEAT1 -> next cycle mem_valid 0, wstrb 0, req_ready 1, no done.
